// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per clock, start/busy/done handshake.
// Optional BIN2BCD_CLAMP_EN: inputs >= 10**DIGITS saturate the result to all nines.
module bin2bcd_seq #(
   parameter int BIN_W  = 10,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int SW = 4 * DIGITS;
   localparam int CW = $clog2(BIN_W) + 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic [BIN_W-1:0] binreg;
   logic [SW-1:0]    scratch;
   logic [SW-1:0]    adj;
   logic [SW-1:0]    post;
   logic [CW-1:0]    cnt;

`ifdef BIN2BCD_CLAMP_EN
   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

   localparam logic [63:0] LIMIT = pow10(DIGITS);

   logic ovf;
`endif

   // post is the scratch value as it will look after this edge's shift
   always_comb begin
      adj = scratch;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
      post = {adj[SW-2:0], binreg[BIN_W-1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         binreg  <= '0;
         scratch <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         bcd     <= '0;
`ifdef BIN2BCD_CLAMP_EN
         ovf     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  binreg  <= bin;
                  scratch <= '0;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  state   <= SHIFT;
`ifdef BIN2BCD_CLAMP_EN
                  ovf     <= (64'(bin) >= LIMIT);
`endif
               end
            end
            SHIFT: begin
               {scratch, binreg} <= {adj, binreg} << 1;
               cnt               <= cnt + 1'b1;
               if (cnt == CW'(BIN_W - 1)) begin
`ifdef BIN2BCD_CLAMP_EN
                  bcd <= ovf ? {DIGITS{4'h9}} : post;
`else
                  bcd <= post;
`endif
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
